// File: rtl/keypad_if.sv
// keypad_if: pins and keydown outputs of the 4x4 keypad scanner.
// master = scanner (drives columns, pulses, digit); slave = keypad/consumer side.
interface keypad_if;
  logic       row_1;
  logic       row_2;
  logic       row_3;
  logic       row_4;
  logic       col_1;
  logic       col_2;
  logic       col_3;
  logic       col_4;
  logic       keydown_start;
  logic       keydown_confirm;
  logic       keydown_clear;
  logic       keydown_num;
  logic [3:0] num;

  modport master (
    input  row_1, row_2, row_3, row_4,
    output col_1, col_2, col_3, col_4,
    output keydown_start, keydown_confirm, keydown_clear, keydown_num, num
  );

  modport slave (
    output row_1, row_2, row_3, row_4,
    input  col_1, col_2, col_3, col_4,
    input  keydown_start, keydown_confirm, keydown_clear, keydown_num, num
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column per clock,
// debounces over whole 4-cycle frames and emits one-cycle keydown pulses.
// Optional digit auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
// Key codes are {column[1:0], row[1:0]} of the single pressed key.
module keypad_scanner #(
  parameter int DEBOUNCE_FRAMES      = 3,
  parameter int REPEAT_DELAY_FRAMES  = 100,
  parameter int REPEAT_PERIOD_FRAMES = 25
) (
  input logic      clk,
  input logic      rst,
  keypad_if.master kp
);

  if (DEBOUNCE_FRAMES < 2 || DEBOUNCE_FRAMES > 15 ||
      REPEAT_DELAY_FRAMES < 1 || REPEAT_PERIOD_FRAMES < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [3:0]  col_n_q, col_n_d;
  logic [11:0] snap_q, snap_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic        kd_start_q, kd_start_d;
  logic        kd_confirm_q, kd_confirm_d;
  logic        kd_clear_q, kd_clear_d;
  logic        kd_num_q, kd_num_d;
  logic [3:0]  num_q, num_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_armed_q, rep_armed_d;
  logic [15:0] rep_next, rep_target;
`endif

  logic [3:0]  row_hit;
  logic [15:0] frame;
  logic        frame_end;
  logic [4:0]  key_cnt;
  logic [3:0]  key_idx;
  logic        no_key, one_key;
  logic        accept, rep_pulse;

  function automatic logic key_is_digit(input logic [3:0] k);
    return (k[3:2] != 2'd3 && k[1:0] != 2'd3) || (k == {2'd1, 2'd3});
  endfunction

  function automatic logic [3:0] key_digit(input logic [3:0] k);
    if (k[1:0] == 2'd3) return 4'd0;
    return 4'(k[1:0]) * 4'd3 + 4'(k[3:2]) + 4'd1;
  endfunction

  // Rows are active-low; the current column's hits complete the frame on its last edge.
  assign row_hit   = ~{kp.row_4, kp.row_3, kp.row_2, kp.row_1};
  assign frame     = {row_hit, snap_q};
  assign frame_end = (col_idx_q == 2'd3);
  assign no_key    = (key_cnt == 5'd0);
  assign one_key   = (key_cnt == 5'd1);
`ifdef KEYPAD_AUTOREPEAT_EN
  assign rep_next   = rep_cnt_q + 16'd1;
  assign rep_target = rep_armed_q ? 16'(REPEAT_PERIOD_FRAMES) : 16'(REPEAT_DELAY_FRAMES);
`endif

  // Count pressed keys in the frame and remember the index of the (last) one found.
  always_comb begin
    key_cnt = 5'd0;
    key_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        key_cnt = key_cnt + 5'd1;
        key_idx = 4'(i);
      end
    end
  end

  // Next-state: column rotation, frame snapshot, per-frame debounce FSM, pulses.
  always_comb begin
    col_idx_d = col_idx_q + 2'd1;
    col_n_d   = {col_n_q[2:0], col_n_q[3]};
    snap_d    = snap_q;
    case (col_idx_q)
      2'd0:    snap_d[3:0]  = row_hit;
      2'd1:    snap_d[7:4]  = row_hit;
      2'd2:    snap_d[11:8] = row_hit;
      default: snap_d       = snap_q;
    endcase
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    accept    = 1'b0;
    rep_pulse = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
`endif
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (one_key) begin
            cand_d  = key_idx;
            cnt_d   = 4'd1;
            state_d = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (one_key && key_idx == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB_CNT) begin
              state_d = HELD;
              accept  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_d   = 16'd0;
              rep_armed_d = 1'b0;
`endif
            end
          end else if (one_key) begin
            cand_d = key_idx;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (no_key) begin
            cnt_d   = 4'd1;
            state_d = REL_DB;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (one_key) begin
            // Multi-key frames fall through and freeze the repeat count.
            if (rep_next == rep_target) begin
              rep_cnt_d   = 16'd0;
              rep_armed_d = 1'b1;
              rep_pulse   = 1'b1;
            end else begin
              rep_cnt_d = rep_next;
            end
          end
`endif
        end
        REL_DB: begin
          if (no_key) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB_CNT) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_d   = 16'd0;
            rep_armed_d = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
    kd_start_d   = accept && (cand_q == {2'd3, 2'd0});
    kd_confirm_d = accept && (cand_q == {2'd3, 2'd1});
    kd_clear_d   = accept && (cand_q == {2'd3, 2'd2});
    kd_num_d     = (accept || rep_pulse) && key_is_digit(cand_q);
    num_d        = kd_num_d ? key_digit(cand_q) : num_q;
  end

  // State and output registers; everything returns to the scan-start state on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_idx_q    <= 2'd0;
      col_n_q      <= 4'b1110;
      snap_q       <= 12'd0;
      cnt_q        <= 4'd0;
      cand_q       <= 4'd0;
      kd_start_q   <= 1'b0;
      kd_confirm_q <= 1'b0;
      kd_clear_q   <= 1'b0;
      kd_num_q     <= 1'b0;
      num_q        <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q    <= 16'd0;
      rep_armed_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      col_n_q      <= col_n_d;
      snap_q       <= snap_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      kd_start_q   <= kd_start_d;
      kd_confirm_q <= kd_confirm_d;
      kd_clear_q   <= kd_clear_d;
      kd_num_q     <= kd_num_d;
      num_q        <= num_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q    <= rep_cnt_d;
      rep_armed_q  <= rep_armed_d;
`endif
    end
  end

  assign kp.col_1           = col_n_q[0];
  assign kp.col_2           = col_n_q[1];
  assign kp.col_3           = col_n_q[2];
  assign kp.col_4           = col_n_q[3];
  assign kp.keydown_start   = kd_start_q;
  assign kp.keydown_confirm = kd_confirm_q;
  assign kp.keydown_clear   = kd_clear_q;
  assign kp.keydown_num     = kd_num_q;
  assign kp.num             = num_q;

endmodule
